// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default fetch geometry, fetch FSM states and word types.
package cpu_pkg;

    localparam int DEF_WORD_W      = 10;
    localparam int DEF_ADDR_W      = 14;
    localparam int DEF_INSTR_WORDS = 3;
    localparam int DEF_RESET_PC    = 'h2000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    typedef logic [DEF_WORD_W-1:0]                 mem_word_t;
    typedef logic [DEF_INSTR_WORDS*DEF_WORD_W-1:0] instr_t;

    // Counter width that stays legal for a single-word instruction.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: memory read port, instruction handshake, redirect and PC.
interface fetch_unit_if #(
    parameter int WORD_W      = cpu_pkg::DEF_WORD_W,
    parameter int ADDR_W      = cpu_pkg::DEF_ADDR_W,
    parameter int INSTR_WORDS = cpu_pkg::DEF_INSTR_WORDS
);
    logic                          mem_req;
    logic [ADDR_W-1:0]             mem_addr;
    logic                          mem_ack;
    logic [WORD_W-1:0]             mem_rdata;
    logic [INSTR_WORDS*WORD_W-1:0] instr;
    logic [ADDR_W-1:0]             instr_pc;
    logic                          instr_valid;
    logic                          instr_ready;
    logic                          redirect;
    logic [ADDR_W-1:0]             redirect_pc;
    logic [ADDR_W-1:0]             pc;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid, pc,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid, pc,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_assembler.sv
// One instruction assembly buffer: slot write-enables by word index, word counter, complete flag.
module instr_assembler
    import cpu_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int INSTR_WORDS = DEF_INSTR_WORDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [WORD_W-1:0]             wdata,
    input  logic                          pop,
    output logic [INSTR_WORDS*WORD_W-1:0] data,
    output logic                          first,
    output logic                          last,
    output logic                          full
);
    localparam int CNT_W = cnt_width(INSTR_WORDS);

    logic [CNT_W-1:0]       cnt;
    logic [INSTR_WORDS-1:0] slot_we;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        slot_we = '0;
        if (wr_en) slot_we[cnt] = 1'b1;
    end

    assign first = (cnt == '0);
    assign last  = (cnt == CNT_W'(INSTR_WORDS - 1));

    // NOTE: the data slots are reset too, so a reset leaves instr at zero rather than stale words.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            for (int i = 0; i < INSTR_WORDS; i++) begin
                if (slot_we[i]) data[(INSTR_WORDS-i)*WORD_W-1 -: WORD_W] <= wdata;
            end
            if (clear) begin
                cnt  <= '0;
                full <= 1'b0;
            end else begin
                if (pop) full <= 1'b0;
                if (wr_en) begin
                    if (last) begin
                        cnt  <= '0;
                        full <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, sequences word reads and presents assembled instructions.
// Define FETCH_PREFETCH_EN for a second buffer that keeps fetching while an instruction waits.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                WORD_W      = DEF_WORD_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                INSTR_WORDS = DEF_INSTR_WORDS,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC)
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int IW = INSTR_WORDS * WORD_W;
`ifdef FETCH_PREFETCH_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [NBUF-1:0]   wr_en, pop, first, last, full;
    logic [IW-1:0]     buf_data [NBUF];
    logic [ADDR_W-1:0] buf_pc   [NBUF];
    logic              wr_sel, last_sel, next_ready, spare_free;
    logic              accept, xfer;

    assign xfer   = bus.instr_valid & bus.instr_ready;
    assign accept = bus.mem_req & bus.mem_ack & ~bus.redirect;

    assign bus.pc       = pc;
    assign bus.mem_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)               pc <= RESET_PC;
        else if (bus.redirect) pc <= bus.redirect_pc;
        else if (accept)       pc <= pc + ADDR_W'(1);
    end

    for (genvar b = 0; b < NBUF; b++) begin : g_buf
        assign wr_en[b] = accept & (wr_sel == 1'(b));

        instr_assembler #(
            .WORD_W      (WORD_W),
            .INSTR_WORDS (INSTR_WORDS)
        ) u_asm (
            .clk   (clk),
            .rst   (rst),
            .clear (bus.redirect),
            .wr_en (wr_en[b]),
            .wdata (bus.mem_rdata),
            .pop   (pop[b]),
            .data  (buf_data[b]),
            .first (first[b]),
            .last  (last[b]),
            .full  (full[b])
        );

        always_ff @(posedge clk) begin
            if (rst)                      buf_pc[b] <= '0;
            else if (wr_en[b] & first[b]) buf_pc[b] <= pc;
        end
    end

`ifdef FETCH_PREFETCH_EN
    // Ping-pong buffers: promotion is a pointer flip, the fill target follows the presented one.
    logic rd_sel;

    always_ff @(posedge clk) begin
        if (rst)       rd_sel <= 1'b0;
        else if (xfer) rd_sel <= ~rd_sel;
    end

    assign wr_sel       = full[rd_sel] ? ~rd_sel : rd_sel;
    assign pop          = xfer ? (NBUF'(1) << rd_sel) : '0;
    assign last_sel     = last[wr_sel];
    assign next_ready   = full[~rd_sel] | (accept & last[~rd_sel]);
    assign spare_free   = ~full[~rd_sel];
    assign bus.instr    = buf_data[rd_sel];
    assign bus.instr_pc = buf_pc[rd_sel];

    a_valid_full: assert property (@(posedge clk) disable iff (rst) (state == HOLD) == full[rd_sel]);
`else
    assign wr_sel       = 1'b0;
    assign pop          = xfer;
    assign last_sel     = last[0];
    assign next_ready   = 1'b0;
    assign spare_free   = 1'b0;
    assign bus.instr    = buf_data[0];
    assign bus.instr_pc = buf_pc[0];

    a_valid_full: assert property (@(posedge clk) disable iff (rst) (state == HOLD) == full[0]);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // A transfer and a redirect in the same cycle both take effect; redirect sets the next state.
    always_comb begin
        state_nxt = state;
        if (bus.redirect) begin
            state_nxt = FETCH;
        end else if (state == FETCH) begin
            if (accept & last_sel) state_nxt = HOLD;
        end else begin
            if (xfer & ~next_ready) state_nxt = FETCH;
        end
    end

    always_comb begin
        bus.instr_valid = (state == HOLD);
        bus.mem_req     = (state == FETCH) | spare_free;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table for the basic stream, plus stall/redirect/wrap/reset sequences.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int WORD_W      = DEF_WORD_W;
    localparam int ADDR_W      = DEF_ADDR_W;
    localparam int INSTR_WORDS = DEF_INSTR_WORDS;
    localparam int IW          = WORD_W * INSTR_WORDS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .INSTR_WORDS(INSTR_WORDS)) bus ();

    fetch_unit #(
        .WORD_W      (WORD_W),
        .ADDR_W      (ADDR_W),
        .INSTR_WORDS (INSTR_WORDS),
        .RESET_PC    (14'h2000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Memory model: three fixed words at 'h2000, a simple address pattern elsewhere.
    function automatic logic [WORD_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        case (a)
            14'h2000: return 10'h3FF;
            14'h2001: return 10'h000;
            14'h2002: return 10'h155;
            default:  return a[9:0] ^ 10'h2B6;
        endcase
    endfunction

    function automatic logic [IW-1:0] exp_instr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] a1, a2;
        a1 = a + 14'd1;
        a2 = a + 14'd2;
        return {mem_fn(a), mem_fn(a1), mem_fn(a2)};
    endfunction

    int ack_delay = 0;
    int wait_cnt;
    assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
    assign bus.mem_rdata = mem_fn(bus.mem_addr);

    always @(posedge clk) begin
        if (rst || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                                    wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else             pass_cnt++;
    endtask

    // Leaves the bench at the falling edge that opens cycle 0.
    task automatic do_reset();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called #1 into a cycle; steps whole cycles until instr_valid, bounded by limit.
    task automatic wait_valid(input string name, input int limit, output int n);
        n = 0;
        while (!bus.instr_valid && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, ".valid_seen"}, bus.instr_valid, 1'b1);
    endtask

    typedef struct {
        bit              ready;
        bit              req;
        logic [ADDR_W-1:0] pc;
        bit              valid;
        logic [IW-1:0]   instr;
        logic [ADDR_W-1:0] ipc;
    } vec_t;

    vec_t vecs [9];
    int   n;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect_pc = '0;

        vecs[0] = '{1'b0, 1'b1, 14'h2000, 1'b0, '0, '0};
        vecs[1] = '{1'b0, 1'b1, 14'h2001, 1'b0, '0, '0};
        vecs[2] = '{1'b0, 1'b1, 14'h2002, 1'b0, '0, '0};
        vecs[3] = '{1'b1, 1'b0, 14'h2003, 1'b1, 30'h3FF00155, 14'h2000};
        vecs[4] = '{1'b0, 1'b1, 14'h2003, 1'b0, '0, '0};
        vecs[5] = '{1'b0, 1'b1, 14'h2004, 1'b0, '0, '0};
        vecs[6] = '{1'b0, 1'b1, 14'h2005, 1'b0, '0, '0};
        vecs[7] = '{1'b1, 1'b0, 14'h2006, 1'b1, exp_instr(14'h2003), 14'h2003};
        vecs[8] = '{1'b0, 1'b1, 14'h2006, 1'b0, '0, '0};

        // Reset state and the back-to-back stream with ack every cycle.
        do_reset();
        #1;
        check("rst.instr", bus.instr, '0);
        check("rst.instr_pc", bus.instr_pc, '0);
        for (int i = 0; i < 9; i++) begin
            bus.instr_ready = vecs[i].ready;
            #1;
            check($sformatf("tbl%0d.mem_req", i), bus.mem_req, vecs[i].req);
            check($sformatf("tbl%0d.pc", i), bus.pc, vecs[i].pc);
            if (vecs[i].req) check($sformatf("tbl%0d.mem_addr", i), bus.mem_addr, vecs[i].pc);
            check($sformatf("tbl%0d.valid", i), bus.instr_valid, vecs[i].valid);
            if (vecs[i].valid) begin
                check($sformatf("tbl%0d.instr", i), bus.instr, vecs[i].instr);
                check($sformatf("tbl%0d.instr_pc", i), bus.instr_pc, vecs[i].ipc);
            end
            @(negedge clk);
        end

        // Two wait cycles before every ack: address held, valid in cycle 9.
        ack_delay = 2;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            #1;
            check($sformatf("stall%0d.valid", c), bus.instr_valid, 1'b0);
            check($sformatf("stall%0d.mem_addr", c), bus.mem_addr, 14'h2000 + 14'(c / 3));
            @(negedge clk);
        end
        #1;
        check("stall.valid9", bus.instr_valid, 1'b1);
        check("stall.instr", bus.instr, 30'h3FF00155);
        check("stall.instr_pc", bus.instr_pc, 14'h2000);
        ack_delay = 0;

        // Consumer holds off for five cycles: instruction stable.
        do_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("hold%0d.valid", k), bus.instr_valid, 1'b1);
            check($sformatf("hold%0d.instr", k), bus.instr, 30'h3FF00155);
            check($sformatf("hold%0d.instr_pc", k), bus.instr_pc, 14'h2000);
`ifndef FETCH_PREFETCH_EN
            check($sformatf("hold%0d.mem_req", k), bus.mem_req, 1'b0);
`endif
            @(negedge clk);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        #1;
`ifdef FETCH_PREFETCH_EN
        check("hold.next_valid", bus.instr_valid, 1'b1);
        check("hold.next_instr_pc", bus.instr_pc, 14'h2003);
        check("hold.next_instr", bus.instr, exp_instr(14'h2003));
`else
        check("hold.next_valid", bus.instr_valid, 1'b0);
        check("hold.next_mem_req", bus.mem_req, 1'b1);
        check("hold.next_mem_addr", bus.mem_addr, 14'h2003);
`endif

        // Redirect during word 1 with a simultaneous ack: that word is discarded.
        do_reset();
        @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 14'h0100;
        #1;
        check("redir.addr_before", bus.mem_addr, 14'h2001);
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        check("redir.mem_addr", bus.mem_addr, 14'h0100);
        check("redir.valid", bus.instr_valid, 1'b0);
        wait_valid("redir", 20, n);
        check("redir.latency", n, 3);
        check("redir.instr_pc", bus.instr_pc, 14'h0100);
        check("redir.instr", bus.instr, exp_instr(14'h0100));
        check("redir.pc", bus.pc, 14'h0103);

        // PC wrap from 3FFF, then redirect coinciding with a transfer.
        do_reset();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 14'h3FFF;
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        check("wrap.mem_addr", bus.mem_addr, 14'h3FFF);
        wait_valid("wrap", 20, n);
        check("wrap.latency", n, 3);
        check("wrap.instr_pc", bus.instr_pc, 14'h3FFF);
        check("wrap.pc", bus.pc, 14'h0002);
        check("wrap.instr", bus.instr, exp_instr(14'h3FFF));
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 14'h0100;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        #1;
        check("xfer_redir.valid", bus.instr_valid, 1'b0);
        check("xfer_redir.mem_addr", bus.mem_addr, 14'h0100);

        // Reset in the middle of assembly drops the partial instruction.
        do_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst.valid", bus.instr_valid, 1'b0);
        check("midrst.pc", bus.pc, 14'h2000);
        check("midrst.mem_req", bus.mem_req, 1'b1);
        check("midrst.instr", bus.instr, '0);
        rst = 1'b0;
        wait_valid("midrst", 20, n);
        check("midrst.latency", n, 3);
        check("midrst.instr_after", bus.instr, 30'h3FF00155);
        check("midrst.instr_pc_after", bus.instr_pc, 14'h2000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
